// File: rtl/dtube_disp_ctrl_if.sv
// AHB-lite bus bundle between the display-update master and the peripheral bus.
interface dtube_disp_ctrl_if;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/dtube_disp_ctrl.sv
// Display update master: converts a 20-bit binary value to six BCD digits
// (one double-dabble step per cycle) and writes them HEX0..HEX5 over AHB-lite.
`ifndef BUS_ADDR_DTUBE_HEX0NUM
`define BUS_ADDR_DTUBE_HEX0NUM 32'h1F00_0010
`endif
`ifndef BUS_ADDR_DTUBE_HEX1NUM
`define BUS_ADDR_DTUBE_HEX1NUM 32'h1F00_0014
`endif
`ifndef BUS_ADDR_DTUBE_HEX2NUM
`define BUS_ADDR_DTUBE_HEX2NUM 32'h1F00_0018
`endif
`ifndef BUS_ADDR_DTUBE_HEX3NUM
`define BUS_ADDR_DTUBE_HEX3NUM 32'h1F00_001C
`endif
`ifndef BUS_ADDR_DTUBE_HEX4NUM
`define BUS_ADDR_DTUBE_HEX4NUM 32'h1F00_0020
`endif
`ifndef BUS_ADDR_DTUBE_HEX5NUM
`define BUS_ADDR_DTUBE_HEX5NUM 32'h1F00_0024
`endif

module dtube_disp_ctrl #(
    parameter logic [31:0] HEX0_ADDR = `BUS_ADDR_DTUBE_HEX0NUM,
    parameter logic [31:0] HEX1_ADDR = `BUS_ADDR_DTUBE_HEX1NUM,
    parameter logic [31:0] HEX2_ADDR = `BUS_ADDR_DTUBE_HEX2NUM,
    parameter logic [31:0] HEX3_ADDR = `BUS_ADDR_DTUBE_HEX3NUM,
    parameter logic [31:0] HEX4_ADDR = `BUS_ADDR_DTUBE_HEX4NUM,
    parameter logic [31:0] HEX5_ADDR = `BUS_ADDR_DTUBE_HEX5NUM,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [19:0]         value,
    input  logic                lz_blank,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ovf,
    dtube_disp_ctrl_if.master   bus
);

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam logic [1:0]  RESP_ERR  = 2'b01;
    localparam logic [19:0] MAX_DISP  = 20'd999999;
    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_ADDR, S_DATA, S_DONE, S_ERR
    } state_t;

    state_t      state_q;
    logic [19:0] bin_q;
    logic [23:0] bcd_q;
    logic [5:0]  blank_q;
    logic        lz_q;
    logic [4:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  tmo_q;
    logic        rdy_q;
    logic        busy_q, done_q, err_q, ovf_q;
    logic [31:0] haddr_q, hwdata_q;
    logic        hwrite_q;
    logic [1:0]  htrans_q;

    logic [23:0] bcd_adj;
    logic [23:0] bcd_d;
    logic [19:0] bin_d;

    // Digit register address for a given digit index.
    function automatic logic [31:0] addr_of(input logic [2:0] i);
        case (i)
            3'd0:    addr_of = HEX0_ADDR;
            3'd1:    addr_of = HEX1_ADDR;
            3'd2:    addr_of = HEX2_ADDR;
            3'd3:    addr_of = HEX3_ADDR;
            3'd4:    addr_of = HEX4_ADDR;
            default: addr_of = HEX5_ADDR;
        endcase
    endfunction

    // Leading-zero mask: digit n>0 is blank when it and every higher digit are zero.
    function automatic logic [5:0] blank_mask(input logic [23:0] b, input logic lz);
        logic [5:0] m;
        m    = '0;
        m[5] = lz && (b[23:20] == 4'd0);
        for (int n = 4; n >= 1; n--) begin
            m[n] = m[n+1] && (b[4*n +: 4] == 4'd0);
        end
        return m;
    endfunction

    // Nibble written for a digit: 4'hF when blanked, otherwise its BCD value.
    function automatic logic [3:0] digit_of(input logic [23:0] b, input logic [5:0] m,
                                            input logic [2:0] i);
        logic [3:0] d;
        case (i)
            3'd0:    d = b[3:0];
            3'd1:    d = b[7:4];
            3'd2:    d = b[11:8];
            3'd3:    d = b[15:12];
            3'd4:    d = b[19:16];
            default: d = b[23:20];
        endcase
        return m[i] ? 4'hF : d;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[22:0], bin_q[19]};
        bin_d = {bin_q[18:0], 1'b0};
    end

    // Sequencer: conversion, per-digit address/data phases, completion and abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            blank_q  <= '0;
            lz_q     <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= TR_IDLE;
        end else begin
            // rdy_q keeps a start that coincides with reset release from being taken.
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && rdy_q) begin
                        bin_q   <= (value > MAX_DISP) ? MAX_DISP : value;
                        ovf_q   <= (value > MAX_DISP);
                        lz_q    <= lz_blank;
                        err_q   <= 1'b0;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd19) begin
                        blank_q  <= blank_mask(bcd_d, lz_q);
                        idx_q    <= '0;
                        tmo_q    <= '0;
                        htrans_q <= TR_NONSEQ;
                        hwrite_q <= 1'b1;
                        haddr_q  <= addr_of(3'd0);
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    htrans_q <= TR_IDLE;
                    hwrite_q <= 1'b0;
                    hwdata_q <= {28'b0, digit_of(bcd_q, blank_q, idx_q)};
                    state_q  <= S_DATA;
                end
                S_DATA: begin
                    if (bus.HRESP == RESP_ERR) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (bus.HREADY) begin
                        if (idx_q == 3'd5) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q    <= idx_q + 3'd1;
                            tmo_q    <= '0;
                            htrans_q <= TR_NONSEQ;
                            hwrite_q <= 1'b1;
                            haddr_q  <= addr_of(idx_q + 3'd1);
                            state_q  <= S_ADDR;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ovf           = ovf_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b000;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_dtube_disp_ctrl.sv
// Directed bench for dtube_disp_ctrl with a small AHB slave model and write monitor.
module tb_dtube_disp_ctrl;

    localparam logic [31:0] A0 = 32'h1F00_0010;
    localparam logic [31:0] A1 = 32'h1F00_0014;
    localparam logic [31:0] A2 = 32'h1F00_0018;
    localparam logic [31:0] A3 = 32'h1F00_001C;
    localparam logic [31:0] A4 = 32'h1F00_0020;
    localparam logic [31:0] A5 = 32'h1F00_0024;
    localparam logic [31:0] NOADDR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] value = '0;
    logic        lz_blank = 1'b0;
    logic        busy, done, err, ovf;

    dtube_disp_ctrl_if bus ();

    dtube_disp_ctrl #(
        .HEX0_ADDR(A0), .HEX1_ADDR(A1), .HEX2_ADDR(A2),
        .HEX3_ADDR(A3), .HEX4_ADDR(A4), .HEX5_ADDR(A5),
        .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .lz_blank(lz_blank),
        .busy(busy), .done(done), .err(err), .ovf(ovf), .bus(bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] HEXA [6];
    initial begin
        HEXA[0] = A0; HEXA[1] = A1; HEXA[2] = A2;
        HEXA[3] = A3; HEXA[4] = A4; HEXA[5] = A5;
    end

    // Bus monitor state
    logic [31:0] aq [$];
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    bit          dpend = 0;
    bit          in_wait = 0;
    bit          hw_changed = 0;
    logic [31:0] paddr = '0;
    logic [31:0] last_hw = '0;

    // Slave behaviour controls
    logic [31:0] wait_addr = NOADDR;
    int          wait_left = 0;
    logic [31:0] err_addr = NOADDR;
    int          err_stage = 0;

    // Results of the last run
    int r_done_cyc, r_done_cnt;
    logic r_busy2, r_err2, r_ovf2;

    // Monitor: records address phases and completed OKAY data phases.
    always @(posedge clk) begin
        if (rst) begin
            dpend = 0;
            in_wait = 0;
        end else begin
            if (dpend) begin
                if (in_wait && bus.HWDATA !== last_hw) hw_changed = 1;
                last_hw = bus.HWDATA;
                if (bus.HREADY) begin
                    if (bus.HRESP == 2'b00) begin
                        wa.push_back(paddr);
                        wd.push_back(bus.HWDATA);
                    end
                    dpend = 0;
                    in_wait = 0;
                end else begin
                    in_wait = 1;
                end
            end
            if (!dpend && bus.HTRANS == 2'b10) begin
                dpend = 1;
                in_wait = 0;
                paddr = bus.HADDR;
                aq.push_back(bus.HADDR);
            end
        end
    end

    // Slave: wait states or a two-cycle ERROR response on a chosen digit register.
    always @(negedge clk) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        if (dpend && paddr == wait_addr && wait_left > 0) begin
            bus.HREADY = 1'b0;
            wait_left--;
        end else if (dpend && paddr == err_addr && err_stage == 1) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = 2'b01;
            err_stage  = 2;
        end else if (dpend && err_stage == 2) begin
            bus.HRESP  = 2'b01;
            err_stage  = 0;
        end
    end

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
    end

    // One start pulse, then follow the run until busy drops; ign_at re-pulses start.
    task automatic run(input logic [19:0] v, input logic lz, input int ign_at);
        int  cyc;
        bit  fin;
        aq.delete(); wa.delete(); wd.delete();
        hw_changed = 0;
        r_done_cyc = 0; r_done_cnt = 0;
        r_busy2 = 1'bx; r_err2 = 1'bx; r_ovf2 = 1'bx;
        @(negedge clk);
        value = v; lz_blank = lz; start = 1'b1;
        cyc = 1;
        fin = 0;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == ign_at) begin
                start = 1'b1;
                value = 20'd0;
            end else begin
                start = 1'b0;
            end
            if (cyc == 2) begin
                r_busy2 = busy; r_err2 = err; r_ovf2 = ovf;
            end
            if (done === 1'b1) begin
                r_done_cnt++;
                r_done_cyc = cyc;
            end
            if (cyc > 2 && busy === 1'b0) fin = 1;
        end
        start = 1'b0;
        nvec++;
        if (!fin) begin
            nerr++;
            $display("FAIL run_bound: busy=%b still set after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        nvec++; if (bus.HTRANS !== 2'b00) begin nerr++; $display("FAIL reset_htrans: got %b want 00", bus.HTRANS); end
        nvec++; if (bus.HADDR !== 32'h0) begin nerr++; $display("FAIL reset_haddr: got %h want 0", bus.HADDR); end
        nvec++; if (bus.HWRITE !== 1'b0) begin nerr++; $display("FAIL reset_hwrite: got %b want 0", bus.HWRITE); end
        nvec++; if (bus.HWDATA !== 32'h0) begin nerr++; $display("FAIL reset_hwdata: got %h want 0", bus.HWDATA); end
        nvec++; if (bus.HSIZE !== 3'b010 || bus.HBURST !== 3'b000 || bus.HMASTLOCK !== 1'b0) begin
            nerr++; $display("FAIL reset_consts: size=%b burst=%b lock=%b want 010 000 0",
                             bus.HSIZE, bus.HBURST, bus.HMASTLOCK);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3:0] e [6];
        e = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        run(20'd123456, 1'b0, 0);
        nvec++; if (r_busy2 !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b want 1", r_busy2); end
        nvec++; if (r_done_cyc != 34) begin nerr++; $display("FAIL basic_done_cycle: got %0d want 34", r_done_cyc); end
        nvec++; if (r_done_cnt != 1) begin nerr++; $display("FAIL basic_done_count: got %0d want 1", r_done_cnt); end
        nvec++; if (err !== 1'b0 || ovf !== 1'b0) begin nerr++; $display("FAIL basic_flags: err=%b ovf=%b want 0 0", err, ovf); end
        nvec++; if (aq.size() != 6) begin nerr++; $display("FAIL basic_naddr: got %0d want 6", aq.size()); end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wa[i] !== HEXA[i] || wd[i] !== {28'b0, e[i]}) begin
                nerr++;
                $display("FAIL basic_digit%0d: got %h@%h want %h@%h", i,
                         (i < wd.size()) ? wd[i] : 32'hx, (i < wa.size()) ? wa[i] : 32'hx, e[i], HEXA[i]);
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0] e1 [6];
        logic [3:0] e2 [6];
        logic [3:0] e3 [6];
        e1 = '{4'd2, 4'd4, 4'hF, 4'hF, 4'hF, 4'hF};
        e2 = '{4'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        e3 = '{4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd1};
        run(20'd42, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e1[i]}) begin
                nerr++; $display("FAIL blank42_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e1[i]);
            end
        end
        run(20'd0, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e2[i]}) begin
                nerr++; $display("FAIL blank0_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e2[i]);
            end
        end
        run(20'd100200, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e3[i]}) begin
                nerr++; $display("FAIL blankmid_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e3[i]);
            end
        end
    endtask

    task automatic test_ovf();
        run(20'hFFFFF, 1'b0, 0);
        nvec++; if (r_ovf2 !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b want 1", r_ovf2); end
        nvec++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        nvec++; if (r_done_cnt != 1) begin nerr++; $display("FAIL ovf_done: got %0d want 1", r_done_cnt); end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== 32'd9) begin
                nerr++; $display("FAIL ovf_digit%0d: got %h want 9", i, (i < wd.size()) ? wd[i] : 32'hx);
            end
        end
        run(20'd1000000, 1'b0, 0);
        nvec++; if (ovf !== 1'b1 || wd.size() != 6 || wd[5] !== 32'd9) begin
            nerr++; $display("FAIL ovf_edge: ovf=%b writes=%0d want ovf 1 and top digit 9", ovf, wd.size());
        end
        run(20'd999999, 1'b0, 0);
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_max_ok: got %b want 0", ovf); end
    endtask

    task automatic test_wait_states();
        logic [3:0] e [6];
        e = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        wait_addr = A2; wait_left = 3;
        run(20'd654321, 1'b0, 0);
        wait_addr = NOADDR; wait_left = 0;
        nvec++; if (r_done_cyc != 37) begin nerr++; $display("FAIL wait_done_cycle: got %0d want 37", r_done_cyc); end
        nvec++; if (hw_changed !== 1'b0) begin nerr++; $display("FAIL wait_hwdata_stable: got changed=%b want 0", hw_changed); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL wait_err: got %b want 0", err); end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e[i]}) begin
                nerr++; $display("FAIL wait_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e[i]);
            end
        end
    endtask

    task automatic test_timeout();
        wait_addr = A2; wait_left = 20;
        run(20'd777777, 1'b0, 0);
        repeat (6) @(negedge clk);
        wait_addr = NOADDR; wait_left = 0;
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL tmo_err: got %b want 1", err); end
        nvec++; if (r_done_cnt != 0) begin nerr++; $display("FAIL tmo_no_done: got %0d want 0", r_done_cnt); end
        nvec++; if (aq.size() != 3 || aq[2] !== A2) begin
            nerr++; $display("FAIL tmo_addr_count: got %0d addresses want 3 ending at %h", aq.size(), A2);
        end
    endtask

    task automatic test_resp_error();
        logic [3:0] e [6];
        e = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        err_addr = A1; err_stage = 1;
        run(20'd123456, 1'b0, 0);
        repeat (3) @(negedge clk);
        err_addr = NOADDR; err_stage = 0;
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL resp_err_flag: got %b want 1", err); end
        nvec++; if (r_done_cnt != 0) begin nerr++; $display("FAIL resp_no_done: got %0d want 0", r_done_cnt); end
        nvec++; if (aq.size() != 2) begin nerr++; $display("FAIL resp_addr_count: got %0d want 2", aq.size()); end
        nvec++; if (wd.size() != 1 || wd[0] !== 32'd6) begin
            nerr++; $display("FAIL resp_writes: got %0d writes want 1 (value 6)", wd.size());
        end
        run(20'd7, 1'b0, 0);
        nvec++; if (r_err2 !== 1'b0) begin nerr++; $display("FAIL resp_err_cleared: got %b want 0", r_err2); end
        nvec++; if (r_done_cyc != 34) begin nerr++; $display("FAIL resp_recover_done: got %0d want 34", r_done_cyc); end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e[i]}) begin
                nerr++; $display("FAIL resp_recover_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e [6];
        bit hit;
        e = '{4'd5, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0};
        aq.delete(); wa.delete(); wd.delete();
        @(negedge clk);
        value = 20'd888888; lz_blank = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk);
            #2;
            if (dpend && paddr == A4) hit = 1;
        end
        nvec++; if (!hit) begin nerr++; $display("FAIL rstmid_reach_hex4: got no HEX4 data phase, required one"); end
        rst = 1'b1;
        #1;
        nvec++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.HWRITE !== 1'b0 || bus.HWDATA !== 32'h0) begin
            nerr++; $display("FAIL rstmid_bus: trans=%b addr=%h write=%b wdata=%h want all 0",
                             bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA);
        end
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin
            nerr++; $display("FAIL rstmid_flags: busy=%b done=%b err=%b ovf=%b want 0000", busy, done, err, ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        value = 20'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_start_at_release: busy=%b want 0", busy); end
        repeat (2) @(negedge clk);
        run(20'd135, 1'b0, 0);
        nvec++; if (aq.size() == 0 || aq[0] !== A0) begin
            nerr++; $display("FAIL rstmid_restart_hex0: first addr %h want %h", (aq.size() > 0) ? aq[0] : 32'hx, A0);
        end
        nvec++; if (r_done_cyc != 34) begin nerr++; $display("FAIL rstmid_restart_done: got %0d want 34", r_done_cyc); end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e[i]}) begin
                nerr++; $display("FAIL rstmid_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e [6];
        e = '{4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
        run(20'd999, 1'b0, 10);
        nvec++; if (r_done_cnt != 1 || r_done_cyc != 34) begin
            nerr++; $display("FAIL b2b_conv_done: count=%0d cycle=%0d want 1 at 34", r_done_cnt, r_done_cyc);
        end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (i >= wd.size() || wd[i] !== {28'b0, e[i]}) begin
                nerr++; $display("FAIL b2b_digit%0d: got %h want %h", i, (i < wd.size()) ? wd[i] : 32'hx, e[i]);
            end
        end
        run(20'd999, 1'b0, 34);
        @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_done_start_ignored: busy=%b want 0", busy); end
        nvec++; if (r_done_cnt != 1) begin nerr++; $display("FAIL b2b_done_count: got %0d want 1", r_done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_ovf();
        test_wait_states();
        test_timeout();
        test_resp_error();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dtube_disp_ctrl.md
Name: dtube_disp_ctrl

Overview:
AHB-lite master that drives the six-digit seven-segment display peripheral from a single binary value. On a start pulse it converts a 20-bit binary value to six BCD digits (sequential double-dabble, one shift per cycle), then issues six single word writes, HEX0 (least significant) first, to the display's digit registers. It sits on a master port of the peripheral bus, beside the CPU's data master, so software or hardware counters can update the display with one strobe.

Parameters:
HEX0_ADDR..HEX5_ADDR, `BUS_ADDR_DTUBE_HEX0NUM..`BUS_ADDR_DTUBE_HEX5NUM, bus address of digit register n.
TIMEOUT, 16, max data-phase cycles waiting for HREADY before abort; 1..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
value  in  20  binary value to display, sampled with start
lz_blank  in  1  sampled with start; 1 = leading zeros written as 4'hF (blank)
busy  out  1  high from the cycle after an accepted start until DONE/ERR exit
done  out  1  one-cycle pulse, all six writes OKAY
err  out  1  sticky; set on ERROR response or timeout; cleared by the next accepted start
ovf  out  1  sticky; value > 999999 clamped; cleared by the next accepted start
HADDR  out  32  address phase
HWRITE  out  1  1 during NONSEQ, 0 otherwise
HSIZE  out  3  constant 3'b010 (word)
HBURST  out  3  constant 3'b000 (SINGLE)
HTRANS  out  2  NONSEQ or IDLE
HMASTLOCK  out  1  constant 0
HWDATA  out  32  {28'b0, digit}, valid in data phase
HREADY  in  1  slave ready
HRESP  in  2  slave response

Behaviour:
- Clock is clk; reset is asynchronous, active-high (rst).
- Reset values: busy=0, done=0, err=0, ovf=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0. Internal shift, BCD, digit index and timeout counter are cleared.
- Reset mid-transfer: the bus returns to IDLE immediately and no further phases are issued. The partially updated display is left as is.
- FSM: IDLE -> CONV -> ADDR -> DATA -> (ADDR | DONE | ERR) -> IDLE.
- IDLE:
  - start=1 latches value, clamped to 999999 (ovf=1 if clamped), and lz_blank.
  - Clears err/ovf, clears BCD to 0, goes to CONV.
  - start while not IDLE is ignored (no queueing).
- CONV:
  - Exactly 20 cycles. Each cycle: every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - Then the blank mask is computed: with lz_blank, a digit n>0 is blank if it and all higher digits are 0. Digit 0 is never blanked.
  - Then idx=0 and the FSM goes to ADDR.
- ADDR (1 cycle): HTRANS=NONSEQ, HWRITE=1, HADDR=HEXidx_ADDR.
- DATA:
  - HTRANS=IDLE, HWRITE=0, HWDATA={28'b0, blank ? 4'hF : bcd[idx]}. HWDATA is held until the phase completes.
  - HRESP==ERROR in any DATA cycle -> ERR.
  - Else HREADY=1 -> if idx==5, DONE; otherwise idx+1 and ADDR.
  - Else the timeout counter increments. Reaching TIMEOUT -> ERR.
  - The counter resets on each ADDR.
- Transfer cost: 2 cycles per digit at zero wait. Start-to-done = 1 + 20 + 12 + 1 = 34 cycles.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1, no further writes, then IDLE with no done pulse.
- busy=1 in CONV, ADDR, DATA, DONE, ERR.
- start coincident with reset release is ignored.

Test Plan:
- value=123456, lz_blank=0, HREADY=1 -> writes HEX0..HEX5 = 6,5,4,3,2,1 in order. Each NONSEQ is followed by one data cycle. done at cycle 34; err=ovf=0.
- value=42, lz_blank=1 -> HWDATA sequence 2,4,F,F,F,F. value=0, lz_blank=1 -> 0,F,F,F,F,F.
- value=20'hFFFFF -> ovf=1; digits 9,9,9,9,9,9; done still pulses.
- HREADY held low 3 cycles on the HEX2 data phase -> HWDATA stable throughout, sequence completes at cycle 37. HREADY low for 16 cycles -> err=1, HEX3..HEX5 never addressed, no done.
- HRESP=ERROR on the HEX1 data phase -> ERR, err=1, no further NONSEQ. The next start clears err and completes normally.
- Assert rst during the HEX4 data phase -> all outputs at reset values in the same cycle. A start after reset release sequences from HEX0. start pulses while busy -> no effect.
